// File: rtl/dcache_ctrl_pkg.sv
// Shared constants for the direct-mapped write-back data cache.
// FSM state codes, line geometry and the line-splice helper.
package dcache_ctrl_pkg;

  localparam int WORD_W   = 16;
  localparam int OFFSET_W = 2;
  localparam int WORDS    = 4;
  localparam int LINE_W   = WORD_W * WORDS;
  localparam int MADDR_W  = 14;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  function automatic logic [LINE_W-1:0] put_word(
    input logic [LINE_W-1:0]   line,
    input logic [OFFSET_W-1:0] off,
    input logic [WORD_W-1:0]   w
  );
    logic [LINE_W-1:0] r;
    r = line;
    r[{off, 4'b0000} +: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: one async read port, one write port.
// Ports: rd_idx -> rd_tag/rd_valid/rd_dirty/rd_line; wr_* updates a whole entry.
module dcache_line_store
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IW = $clog2(NUM_LINES),
  parameter int TW = MADDR_W - IW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     rd_idx,
  output logic [TW-1:0]     rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [TW-1:0]     wr_tag,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [LINE_W-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data need no reset: valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller.
// Ports: CPU side addr/re/we/wrData/rdData/stall; memory side mem_*.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         addr,
  input  logic                re,
  input  logic                we,
  input  logic [15:0]         wrData,
  output logic [15:0]         rdData,
  output logic                stall,
  output logic [MADDR_W-1:0]  mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_rdy
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = MADDR_W - IW;

  logic [1:0] state_q, state_d;

  logic [OFFSET_W-1:0] off;
  logic [IW-1:0]       idx;
  logic [TW-1:0]       tag;

  assign off = addr[1:0];
  assign idx = addr[1+IW:2];
  assign tag = addr[15:2+IW];

  logic [TW-1:0]     rd_tag;
  logic              rd_valid;
  logic              rd_dirty;
  logic [LINE_W-1:0] rd_line;
  logic              wr_en;
  logic [TW-1:0]     wr_tag;
  logic              wr_valid;
  logic              wr_dirty;
  logic [LINE_W-1:0] wr_line;

  dcache_line_store #(
    .NUM_LINES(NUM_LINES)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (idx),
    .rd_tag  (rd_tag),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_line (rd_line),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_tag  (wr_tag),
    .wr_valid(wr_valid),
    .wr_dirty(wr_dirty),
    .wr_line (wr_line)
  );

  logic        hit;
  logic        req;
  logic [15:0] word;
  logic        stall_c;
  logic [15:0] rd_c;

  assign hit  = rd_valid && (rd_tag == tag);
  assign req  = re || we;
  assign word = rd_line[{off, 4'b0000} +: WORD_W];

  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    rd_c      = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_en     = 1'b0;
    wr_tag    = rd_tag;
    wr_valid  = rd_valid;
    wr_dirty  = rd_dirty;
    wr_line   = rd_line;
    unique case (state_q)
      ST_IDLE: begin
        if (req && hit) begin
          if (we) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_line  = put_word(rd_line, off, wrData);
          end else begin
            rd_c = word;
          end
        end else if (req) begin
          stall_c = 1'b1;
          state_d = (rd_valid && rd_dirty)
                  ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        stall_c   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, idx};
        mem_wdata = rd_line;
        if (mem_rdy) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          state_d  = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        stall_c  = 1'b1;
        mem_re   = 1'b1;
        mem_addr = addr[15:2];
        if (mem_rdy) begin
          wr_en    = 1'b1;
          wr_tag   = tag;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_line  = mem_rdata;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must silence the CPU side at once, even with a request held.
  assign stall  = rst_n & stall_c;
  assign rdData = rst_n ? rd_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a transaction-level cache model.
// Directed checks pin the model with hand-computed values.
module tb_dcache_ctrl;

  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wrData = '0;
  logic [15:0] rdData;
  logic        stall;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;

  dcache_ctrl #(.NUM_LINES(NL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wrData   (wrData),
    .rdData   (rdData),
    .stall    (stall),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rdy  (mem_rdy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [63:0] mem [logic [13:0]];
  int lat_wb = 1;
  int lat_fill = 1;
  int busy = 0;

  logic [10:0] m_tag   [NL];
  bit          m_val   [NL];
  bit          m_dirty [NL];
  logic [63:0] m_line  [NL];

  function automatic logic [63:0] mem_rd(input logic [13:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: rdy pulses on the Nth cycle of a transfer; noise when idle.
  always @(negedge clk) begin
    if (mem_re || mem_we) begin
      busy++;
      mem_rdata = mem_re ? mem_rd(mem_addr) : {$urandom, $urandom};
      mem_rdy = (busy >= (mem_we ? lat_wb : lat_fill));
      if (mem_rdy) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        busy = 0;
      end
    end else begin
      busy = 0;
      mem_rdy = ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom};
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NL; i++) begin
      m_val[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_req(input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] d,
                        output int nst, output logic [15:0] rd,
                        output logic [13:0] wb_a,
                        output logic [63:0] wb_d,
                        output logic [13:0] fl_a);
    logic [2:0]  idx;
    logic [10:0] tg;
    bit hit, vict, bad_order, done;
    int nwe, nre, exp_st, sh;
    idx = a[4:2];
    tg = a[15:5];
    sh = int'(a[1:0]) * 16;
    hit = m_val[idx] && (m_tag[idx] == tg);
    vict = !hit && m_val[idx] && m_dirty[idx];
    exp_st = hit ? 0 : (vict ? lat_wb : 0) + lat_fill + 1;
    @(posedge clk);
    #1;
    re = r;
    we = w;
    addr = a;
    wrData = d;
    nst = 0; nwe = 0; nre = 0;
    wb_a = '0; wb_d = '0; fl_a = '0;
    rd = '0;
    bad_order = 0;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        rd = rdData;
      end else begin
        nst++;
        chk("mem_excl", {63'd0, mem_re & mem_we}, 64'd0);
        if (mem_we) begin
          if (nwe == 0) begin
            wb_a = mem_addr;
            wb_d = mem_wdata;
          end
          nwe++;
          if (nre > 0) bad_order = 1;
        end
        if (mem_re) begin
          if (nre == 0) fl_a = mem_addr;
          nre++;
        end
      end
    end
    chk("timeout", {63'd0, done}, 64'd1);
    chk("stall_cycles", nst, exp_st);
    chk("wb_cycles", nwe, vict ? lat_wb : 0);
    chk("fill_cycles", nre, hit ? 0 : lat_fill);
    chk("wb_before_fill", {63'd0, bad_order}, 64'd0);
    if (vict) begin
      chk("wb_addr", wb_a, {m_tag[idx], idx});
      chk("wb_data", wb_d, m_line[idx]);
    end
    if (!hit) begin
      chk("fill_addr", fl_a, a[15:2]);
      m_tag[idx] = tg;
      m_val[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_line[idx] = mem_rd(a[15:2]);
    end
    if (r && !w) chk("rdData", rd, m_line[idx][sh +: 16]);
    if (w) begin
      m_line[idx][sh +: 16] = d;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic do_idle(input logic [15:0] a);
    @(posedge clk);
    #1;
    re = 1'b0;
    we = 1'b0;
    addr = a;
    @(negedge clk);
    chk("idle_outs", {45'd0, stall, rdData, mem_re, mem_we}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst;
    logic [15:0] rd;
    logic [13:0] wa, fa;
    logic [63:0] wd;
    bit seen;
    clear_model();
    mem[14'h0004] = 64'h0004_0003_0002_0001;
    mem[14'h000C] = 64'h00C4_00C3_00C2_00C1;

    // Held request during reset must not stall or touch memory.
    #12;
    re = 1'b1;
    addr = 16'h0010;
    #1;
    chk("rst_outs", {45'd0, stall, rdData, mem_re, mem_we}, 64'd0);
    re = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    lat_fill = 3;
    do_req(1, 0, 16'h0010, 16'h0, nst, rd, wa, wd, fa);
    chk("d_fill_stall", nst, 4);
    chk("d_fill_addr", fa, 14'h0004);
    chk("d_fill_rd", rd, 16'h0001);

    do_req(0, 1, 16'h0012, 16'hBEEF, nst, rd, wa, wd, fa);
    chk("d_wr_hit_stall", nst, 0);
    do_req(1, 0, 16'h0012, 16'h0, nst, rd, wa, wd, fa);
    chk("d_rd_beef", rd, 16'hBEEF);

    lat_wb = 2;
    lat_fill = 2;
    do_req(1, 0, 16'h0030, 16'h0, nst, rd, wa, wd, fa);
    chk("d_evict_stall", nst, 5);
    chk("d_wb_addr", wa, 14'h0004);
    chk("d_wb_data", wd, 64'h0004_BEEF_0002_0001);
    chk("d_evict_fill", fa, 14'h000C);
    chk("d_evict_rd", rd, 16'h00C1);

    do_idle(16'h0030);

    do_req(1, 0, 16'h0010, 16'h0, nst, rd, wa, wd, fa);
    chk("d_refill_stall", nst, 3);
    do_req(1, 1, 16'h0011, 16'h1234, nst, rd, wa, wd, fa);
    chk("d_rw_stall", nst, 0);
    do_req(1, 0, 16'h0011, 16'h0, nst, rd, wa, wd, fa);
    chk("d_rw_rd", rd, 16'h1234);

    // Reset while the fill for 0x0050 is outstanding.
    lat_wb = 1;
    lat_fill = 10;
    @(posedge clk);
    #1;
    re = 1'b1;
    we = 1'b0;
    addr = 16'h0050;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = mem_re;
    end
    chk("r_alloc_seen", {63'd0, seen}, 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_outs",
        {45'd0, stall, rdData, mem_re, mem_we}, 64'd0);
    re = 1'b0;
    clear_model();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    lat_fill = 2;
    do_req(1, 0, 16'h0010, 16'h0, nst, rd, wa, wd, fa);
    chk("r_miss_stall", nst, 3);
    chk("r_miss_addr", fa, 14'h0004);
    chk("r_miss_rd", rd, 16'h0001);

    for (int n = 0; n < 300; n++) begin
      int op;
      logic [15:0] a;
      op = $urandom_range(0, 7);
      lat_wb = $urandom_range(1, 4);
      lat_fill = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, 127));
      if (op == 0) do_idle(a);
      else if (op < 4)
        do_req(1, 0, a, 16'h0, nst, rd, wa, wd, fa);
      else if (op < 7)
        do_req(0, 1, a, 16'($urandom), nst, rd, wa, wd, fa);
      else
        do_req(1, 1, a, 16'($urandom), nst, rd, wa, wd, fa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of 2, 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  16  CPU word address: offset=[1:0], index=[1+IW:2] with IW=log2(NUM_LINES), tag=remaining upper bits.
REQ-005 SHALL have port re  input  1  CPU read request.
REQ-006 SHALL have port we  input  1  CPU write request.
REQ-007 SHALL have port wrData  input  16  CPU store data.
REQ-008 SHALL have port rdData  output  16  CPU load data.
REQ-009 SHALL have port stall  output  1  request not complete; CPU holds addr/re/we/wrData stable while high.
REQ-010 SHALL have port mem_addr  output  14  main-memory line address (addr[15:2]).
REQ-011 SHALL have port mem_re  output  1  line fill request.
REQ-012 SHALL have port mem_we  output  1  line write-back request.
REQ-013 SHALL have port mem_wdata  output  64  victim line, word 0 in [15:0].
REQ-014 SHALL have port mem_rdata  input  64  fill line, word 0 in [15:0].
REQ-015 SHALL have port mem_rdy  input  1  one-cycle pulse: current mem_re/mem_we transfer done.

Function
REQ-016 SHALL implement a write-back, write-allocate, direct-mapped cache with 4 x 16-bit words per line plus per-line tag, valid and dirty bits.
REQ-017 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-018 SHALL compute hit combinationally in IDLE: valid[index] and tag[index]==addr tag.
REQ-019 SHALL, on read hit in IDLE, drive rdData = line word[offset] in the same cycle, with stall=0.
REQ-020 SHALL, on write hit in IDLE, hold stall=0 and, at the next edge, write wrData into word[offset] and set dirty[index].
REQ-021 SHALL, on miss (re or we) in IDLE, assert stall combinationally in that cycle; next state WRITEBACK if victim valid and dirty, else ALLOCATE.
REQ-022 SHALL, in WRITEBACK, hold mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim line, stall=1 until mem_rdy; then go to ALLOCATE and clear dirty[index].
REQ-023 SHALL, in ALLOCATE, hold mem_re=1, mem_addr=addr[15:2], stall=1 until mem_rdy; then load mem_rdata, tag, valid=1, dirty=0, and go to IDLE.
REQ-024 SHALL, after ALLOCATE, re-evaluate the held request in IDLE as a hit (completes there; write sets dirty).
REQ-025 SHALL never assert mem_re and mem_we together; both are 0 in IDLE.
REQ-026 SHALL ignore mem_rdy in IDLE.
REQ-027 SHALL treat re=we=1 as a write.
REQ-028 SHALL drive stall=0 and rdData=0 when re=we=0 in IDLE; no state changes.
REQ-029 SHALL, when the index matches but the tag differs, evict the line (conflict miss).
REQ-030 SHALL have miss latency with a fill delay of N cycles and no write-back of N+1 stall cycles; with write-back, W+N+1 stall cycles.

Reset
REQ-031 SHALL, on rst_n low (including mid-WRITEBACK/ALLOCATE), go to IDLE and clear all valid and dirty bits; mem_re=mem_we=0, stall=0, rdData=0 immediately, with no pending transfer resumed.
REQ-032 SHALL not require reset of tag/data storage.

Structure
REQ-033 SHALL place the FSM state enum, OFFSET/line-width constants and the mem line width in the shared defines package.
REQ-034 SHALL keep tag/valid/dirty/data arrays in one sub-module, dcache_line_store (one read port, one write port).

Verification
REQ-035 SHALL cover: after reset, read 0x0010 with a fill of 64'h0004_0003_0002_0001 and mem_rdy after 3 cycles -> mem_re=1 with mem_addr=0x0004, stall for 4 cycles, then rdData=0x0001.
REQ-036 SHALL cover: write 0xBEEF to 0x0012 after the line is cached -> stall=0; a subsequent read of 0x0012 returns 0xBEEF and dirty=1.
REQ-037 SHALL cover: read 0x0030 (same index 4, new tag) -> mem_we with mem_addr=0x0004 and mem_wdata=64'h0004_BEEF_0002_0001, then mem_re with mem_addr=0x000C.
REQ-038 SHALL cover: rst_n low during ALLOCATE -> mem_re drops asynchronously; a subsequent read of 0x0010 misses again.
REQ-039 SHALL cover: re=we=1, wrData=0x1234, addr=0x0011 on hit -> treated as a write; a read of 0x0011 returns 0x1234.
